// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hs_pkg
//  Description : Shared constants for the four-phase handshake receiver:
//                FSM state encoding and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

  // FSM state encoding (2-bit)
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] CAPTURE = 2'b01;
  localparam logic [1:0] ACK     = 2'b10;

  // Default configuration
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FIFO_DEPTH  = 4;

endpackage : hs_pkg
`default_nettype wire

// File: rtl/hs_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hs_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO used to buffer
//                words captured by the handshake receiver.
//  Ports       : clk, reset (sync, active-low)
//                push / push_data : write side (ignored when full)
//                pop              : read side (ignored when empty)
//                dout             : head word; holds last popped word when empty
//                full, empty, fill: status
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_rx_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (fill_q == (AW+1)'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

  // When empty, present the most recently popped word rather than a stale slot
  assign dout = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    // DEPTH is a power of two, so natural pointer overflow gives the wrap
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    last_d   = pop_ok  ? mem_q[rd_ptr_q]   : last_q;
    fill_d   = fill_q;
    case ({push_ok, pop_ok})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule : hs_rx_fifo
`default_nettype wire

// File: rtl/handshake_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_receiver
//  Description : Destination end of a four-phase req/ack clock crossing.
//                Synchronizes req_async, captures the source-held data word,
//                returns a registered ack and buffers words in a FWFT FIFO.
//  Ports       : clk, reset (sync, active-low), enable
//                req_async, data_in -> ack           (source side)
//                dout, dout_valid, dout_ready        (consumer side)
//                fill, xfer_count                    (status)
//  Option      : HS_PARITY_EN adds parity_in (even parity over data_in) and a
//                sticky parity_err; mismatched words are acked but dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_receiver
  import hs_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          req_async,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          ack,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic [7:0]                    xfer_count
`ifdef HS_PARITY_EN
  ,
  input  logic                          parity_in,
  output logic                          parity_err
`endif
);

  // --------------------------------------------------------------------------
  // req synchronizer chain; req_s is the last stage
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
  assign req_s  = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // FSM / datapath state
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       ack_q, ack_d;
  logic [7:0] xfer_count_q, xfer_count_d;
  logic       push;
  logic       word_ok;
  logic       fifo_full;
  logic       fifo_empty;

`ifdef HS_PARITY_EN
  logic parity_err_q, parity_err_d;
  // Even parity: parity_in must make the total count of ones even
  assign word_ok    = ((^data_in) == parity_in);
  assign parity_err = parity_err_q;
`else
  assign word_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      xfer_count_q <= '0;
`ifdef HS_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      ack_q        <= ack_d;
      xfer_count_q <= xfer_count_d;
`ifdef HS_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic. enable and full only gate leaving IDLE, so a
  // handshake already in progress always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_s && enable && !fifo_full) state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. ack is registered from the next state so it changes on
  // the same edge the FSM enters/leaves ACK, glitch-free toward the source.
  always_comb begin
    ack_d        = (state_d == ACK);
    push         = (state_q == CAPTURE) && word_ok;
    xfer_count_d = push ? xfer_count_q + 8'd1 : xfer_count_q;
`ifdef HS_PARITY_EN
    parity_err_d = parity_err_q || ((state_q == CAPTURE) && !word_ok);
`endif
  end

  assign ack        = ack_q;
  assign xfer_count = xfer_count_q;
  assign dout_valid = !fifo_empty;

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  hs_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (data_in),
    .pop       (dout_ready),
    .dout      (dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

endmodule : handshake_receiver
`default_nettype wire
